// File: rtl/lag_correlator.sv
// Pairwise lagged coincidence counter with per-channel autocounts. Each window's
// accumulators are snapshotted and streamed out as a ready/valid word sequence.
module lag_correlator #(
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned MAX_LAG    = 4,
  parameter int unsigned LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] pulse_in,
  input  logic                  sample_pulse,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  integration_len,
  input  logic                  rd_ready,
  output logic [RESOLUTION-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  window_pulse,
  output logic                  overrun
);

  localparam int unsigned NUM_LAGS  = 2 * MAX_LAG + 1;
  localparam int unsigned NUM_PAIRS = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
  localparam int unsigned NUM_WORDS = NUM_PAIRS * NUM_LAGS + NUM_INPUTS;
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [MAX_LAG-1:0]      hist_q [NUM_INPUTS];
  logic [MAX_LAG:0]        hfull  [NUM_INPUTS];
  logic [NUM_WORDS-1:0]    inc;
  logic [RESOLUTION-1:0]   acc_q   [NUM_WORDS];
  logic [RESOLUTION-1:0]   acc_nxt [NUM_WORDS];
  logic [RESOLUTION-1:0]   snap_q  [NUM_WORDS];
  logic [LEN_WIDTH-1:0]    cnt_q, len_q, len_in, len_eff;
  logic                    accept, win_end, last_xfer, load;
  logic                    window_pulse_q, overrun_q;

  // Bit d of hfull[k] is the input value d accepted samples ago (bit 0 is live).
  for (genvar gk = 0; gk < NUM_INPUTS; gk++) begin : g_hist
    assign hfull[gk] = {hist_q[gk], pulse_in[gk]};
    assign inc[NUM_PAIRS*NUM_LAGS+gk] = pulse_in[gk];
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_i
    for (genvar gj = gi + 1; gj < NUM_INPUTS; gj++) begin : g_j
      localparam int unsigned Pair = gi * NUM_INPUTS - gi * (gi + 1) / 2 + (gj - gi - 1);
      for (genvar gl = 0; gl < NUM_LAGS; gl++) begin : g_l
        localparam int Lag = int'(gl) - int'(MAX_LAG);
        if (Lag >= 0) begin : g_pos
          assign inc[Pair*NUM_LAGS+gl] = hfull[gi][0] & hfull[gj][Lag];
        end else begin : g_neg
          assign inc[Pair*NUM_LAGS+gl] = hfull[gi][-Lag] & hfull[gj][0];
        end
      end
    end
  end

  for (genvar gw = 0; gw < NUM_WORDS; gw++) begin : g_acc
    assign acc_nxt[gw] = (inc[gw] && (acc_q[gw] != {RESOLUTION{1'b1}})) ?
                         acc_q[gw] + RESOLUTION'(1) : acc_q[gw];
  end

  // Length is latched on the first accepted sample of each window; 0 means 1.
  assign len_in    = (integration_len == '0) ? LEN_WIDTH'(1) : integration_len;
  assign len_eff   = (cnt_q == '0) ? len_in : len_q;
  assign accept    = sample_pulse & enable;
  assign win_end   = accept && ((cnt_q + LEN_WIDTH'(1)) == len_eff);
  assign last_xfer = (state_q == StStream) && rd_ready && (idx_q == LAST_IDX);
  assign load      = win_end && ((state_q == StIdle) || last_xfer);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      len_q          <= '0;
      window_pulse_q <= 1'b0;
      overrun_q      <= 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) hist_q[k] <= '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
        acc_q[w]  <= '0;
        snap_q[w] <= '0;
      end
    end else begin
      window_pulse_q <= win_end;
      if (win_end && !load) overrun_q <= 1'b1;
      if (accept) begin
        for (int k = 0; k < NUM_INPUTS; k++) hist_q[k] <= hfull[k][MAX_LAG-1:0];
        if (cnt_q == '0) len_q <= len_in;
        cnt_q <= win_end ? '0 : cnt_q + LEN_WIDTH'(1);
        for (int w = 0; w < NUM_WORDS; w++) acc_q[w] <= win_end ? '0 : acc_nxt[w];
      end
      if (load) begin
        for (int w = 0; w < NUM_WORDS; w++) snap_q[w] <= acc_nxt[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        if (load) begin
          idx_d = '0;
        end else if (rd_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_valid     = (state_q == StStream);
  assign rd_last      = rd_valid && (idx_q == LAST_IDX);
  assign rd_data      = rd_valid ? snap_q[idx_q] : '0;
  assign window_pulse = window_pulse_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_lag_correlator.sv
// Directed bench for lag_correlator with 3 inputs, max lag 2, 4-bit counters.
module tb_lag_correlator;

  localparam int NW = 18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  pulse_in = '0;
  logic        sample_pulse = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] integration_len = 32'd4;
  logic        rd_ready = 1'b0;
  logic [3:0]  rd_data;
  logic        rd_valid, rd_last, window_pulse, overrun;

  int checks = 0;
  int errors = 0;
  int exp_w [NW];

  always #5 clk = ~clk;

  lag_correlator #(
    .NUM_INPUTS(3),
    .RESOLUTION(4),
    .MAX_LAG   (2),
    .LEN_WIDTH (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pulse_in       (pulse_in),
    .sample_pulse   (sample_pulse),
    .enable         (enable),
    .integration_len(integration_len),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_last        (rd_last),
    .window_pulse   (window_pulse),
    .overrun        (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [2:0] v);
    pulse_in     = v;
    sample_pulse = 1'b1;
    enable       = 1'b1;
    tick();
    sample_pulse = 1'b0;
    pulse_in     = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_pair(input int p, input int a, input int b, input int c, input int d,
                          input int e);
    exp_w[p*5+0] = a;
    exp_w[p*5+1] = b;
    exp_w[p*5+2] = c;
    exp_w[p*5+3] = d;
    exp_w[p*5+4] = e;
  endtask

  task automatic set_autos(input int a, input int b, input int c);
    exp_w[15] = a;
    exp_w[16] = b;
    exp_w[17] = c;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!rd_valid && n < 10) begin
      tick();
      n++;
    end
    check("rd_valid_wait", rd_valid, 1);
  endtask

  task automatic read_words(input int first, input int last);
    for (int w = first; w <= last; w++) begin
      check($sformatf("word%0d_valid", w), rd_valid, 1);
      check($sformatf("word%0d_data", w), rd_data, exp_w[w]);
      check($sformatf("word%0d_last", w), rd_last, (w == NW - 1));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_window_pulse", window_pulse, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;

    // All ones for 4 samples, with an enable-low gap that must not count
    integration_len = 32'd4;
    sample(3'b111);
    sample(3'b111);
    pulse_in     = 3'b111;
    sample_pulse = 1'b1;
    enable       = 1'b0;
    tick();
    tick();
    sample_pulse = 1'b0;
    sample(3'b111);
    check("t1_no_early_pulse", window_pulse, 0);
    check("t1_no_early_valid", rd_valid, 0);
    sample(3'b111);
    check("t1_window_pulse", window_pulse, 1);
    set_pair(0, 2, 3, 4, 3, 2);
    set_pair(1, 2, 3, 4, 3, 2);
    set_pair(2, 2, 3, 4, 3, 2);
    set_autos(4, 4, 4);
    wait_valid();
    read_words(0, 17);
    check("t1_idle_after", rd_valid, 0);
    check("t1_pulse_cleared", window_pulse, 0);

    // Input0 at sample 1, input1 at sample 2: only pair(0,1) lag -1 and autos
    do_reset();
    sample(3'b001);
    sample(3'b010);
    sample(3'b000);
    sample(3'b000);
    set_pair(0, 0, 1, 0, 0, 0);
    set_pair(1, 0, 0, 0, 0, 0);
    set_pair(2, 0, 0, 0, 0, 0);
    set_autos(1, 1, 0);
    wait_valid();
    read_words(0, 17);

    // Length 20 saturates every counter at 15
    do_reset();
    integration_len = 32'd20;
    repeat (16) sample(3'b111);
    check("t3_no_early_valid", rd_valid, 0);
    repeat (4) sample(3'b111);
    check("t3_window_pulse", window_pulse, 1);
    for (int w = 0; w < NW; w++) exp_w[w] = 15;
    wait_valid();
    read_words(0, 17);

    // Backpressure at word 3 while a second window ends mid-stream
    do_reset();
    integration_len = 32'd4;
    repeat (4) sample(3'b111);
    set_pair(0, 2, 3, 4, 3, 2);
    set_pair(1, 2, 3, 4, 3, 2);
    set_pair(2, 2, 3, 4, 3, 2);
    set_autos(4, 4, 4);
    wait_valid();
    read_words(0, 2);
    for (int c = 0; c < 5; c++) begin
      rd_ready     = 1'b0;
      pulse_in     = 3'b111;
      enable       = 1'b1;
      sample_pulse = (c < 4);
      check($sformatf("stall%0d_data", c), rd_data, exp_w[3]);
      check($sformatf("stall%0d_valid", c), rd_valid, 1);
      tick();
      if (c == 3) begin
        check("t4_window_pulse", window_pulse, 1);
        check("t4_overrun", overrun, 1);
      end
    end
    sample_pulse = 1'b0;
    pulse_in     = '0;
    read_words(3, 17);
    check("t4_dropped_snapshot", rd_valid, 0);
    check("t4_overrun_sticky", overrun, 1);

    // Reset at word 7 kills the stream and clears overrun
    repeat (4) sample(3'b111);
    for (int w = 0; w < 15; w++) exp_w[w] = 4;
    set_autos(4, 4, 4);
    wait_valid();
    check("t5_overrun_before", overrun, 1);
    read_words(0, 6);
    rd_ready = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    rd_ready = 1'b0;
    check("t5_rd_valid", rd_valid, 0);
    check("t5_overrun", overrun, 0);
    check("t5_rd_last", rd_last, 0);
    check("t5_rd_data", rd_data, 0);
    rd_ready = 1'b1;
    tick();
    tick();
    rd_ready = 1'b0;
    check("t5_no_resume", rd_valid, 0);
    repeat (4) sample(3'b111);
    set_pair(0, 2, 3, 4, 3, 2);
    set_pair(1, 2, 3, 4, 3, 2);
    set_pair(2, 2, 3, 4, 3, 2);
    set_autos(4, 4, 4);
    wait_valid();
    read_words(0, 17);

    // Zero length: every accepted sample is a window
    do_reset();
    integration_len = 32'd0;
    sample(3'b101);
    check("t6_window_pulse", window_pulse, 1);
    set_pair(0, 0, 0, 0, 0, 0);
    set_pair(1, 0, 0, 1, 0, 0);
    set_pair(2, 0, 0, 0, 0, 0);
    set_autos(1, 0, 1);
    wait_valid();
    read_words(0, 17);
    sample(3'b010);
    set_pair(0, 0, 1, 0, 0, 0);
    set_pair(1, 0, 0, 0, 0, 0);
    set_pair(2, 0, 0, 0, 1, 0);
    set_autos(0, 1, 0);
    wait_valid();
    read_words(0, 17);
    check("t6_idle_after", rd_valid, 0);
    check("t6_no_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
